// File: rtl/inst_fetch_queue_pkg.sv
// rtl/inst_fetch_queue_pkg.sv - shared CPU types for the instruction fetch queue
package inst_fetch_queue_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [31:0]       inst;
  } fetch_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fifo.sv
// rtl/inst_fetch_queue_fifo.sv - fetch_fifo: circular entry store with flush
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign rdata = mem_q[rptr_q];

  always_comb begin
    mem_d   = mem_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    // A flush drops everything, including a pop accepted in the same cycle.
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wptr_q] = wdata;
        wptr_d        = wptr_q + PW'(1);
      end
      if (do_pop) begin
        rptr_d = rptr_q + PW'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// rtl/inst_fetch_queue.sv - PC sequencer feeding a decode-side fetch queue
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int               DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'd0,
  parameter logic [ADDR_W-1:0] HALT_PC  = 32'd18
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] inst_addr,
  input  logic [31:0]       instruction,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              push, pop, full, empty;
  fetch_entry_t      wr_entry, head;

  assign inst_addr = pc_q;
  assign out_valid = !empty;
  assign pop       = out_valid && out_ready;
  assign out_inst  = head.inst;
  assign out_pc    = head.pc;
  assign halted    = (state_q == HALTED);
  assign wr_entry  = '{pc: pc_q, inst: instruction};
  // A full queue still accepts a fetch when decode drains the head this cycle.
  assign push      = (state_q == RUN) && (pc_q != HALT_PC) && !redirect_valid && (!full || pop);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    if (redirect_valid) begin
      state_d = RUN;
      pc_d    = redirect_addr;
    end else if (state_q == RUN && pc_q == HALT_PC) begin
      state_d = HALTED;
    end else if (push) begin
      pc_d = pc_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH),
    .WIDTH($bits(fetch_entry_t))
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .pop  (pop),
    .flush(redirect_valid),
    .wdata(wr_entry),
    .full (full),
    .empty(empty),
    .rdata(head)
  );

endmodule

// File: tb/tb_inst_fetch_queue.sv
// tb/tb_inst_fetch_queue.sv - directed self-checking bench for inst_fetch_queue
module tb_inst_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] inst_addr;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        halted;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Memory word k holds 0x1000 + k.
  assign instruction = 32'h1000 + inst_addr;

  inst_fetch_queue #(.DEPTH(4), .RESET_PC(32'd0), .HALT_PC(32'd18)) dut (
    .clk           (clk),
    .rst           (rst),
    .inst_addr     (inst_addr),
    .instruction   (instruction),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_inst      (out_inst),
    .out_pc        (out_pc),
    .halted        (halted)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_addr = 32'd0; out_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; redirect_valid = 1'b0; redirect_addr = 32'd0; out_ready = 1'b1;
    tick();
    tick();
    tests_run++;
    if (inst_addr !== 32'd0) begin tests_failed++; $display("FAIL reset_inst_addr got %0d want 0", inst_addr); end
    tests_run++;
    if (out_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests_run++;
    if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted got %b want 0", halted); end
  endtask

  task automatic test_stream();
    rst = 1'b0; out_ready = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_inst !== 32'h1000) begin
      tests_failed++; $display("FAIL stream_first got v=%b pc=%0d inst=%h want v=1 pc=0 inst=1000", out_valid, out_pc, out_inst);
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== k || out_inst !== 32'h1000 + k) begin
        tests_failed++; $display("FAIL stream_k%0d got v=%b pc=%0d inst=%h want v=1 pc=%0d", k, out_valid, out_pc, out_inst, k);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    tests_run++;
    if (inst_addr !== 32'd4) begin tests_failed++; $display("FAIL bp_inst_addr got %0d want 4", inst_addr); end
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0) begin tests_failed++; $display("FAIL bp_hold got v=%b pc=%0d want v=1 pc=0", out_valid, out_pc); end
    out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== k) begin
        tests_failed++; $display("FAIL bp_drain_k%0d got v=%b pc=%0d want v=1 pc=%0d", k, out_valid, out_pc, k);
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b0;
    tick(); tick(); tick();
    redirect_valid = 1'b1; redirect_addr = 32'd9;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || inst_addr !== 32'd9) begin
      tests_failed++; $display("FAIL redirect_flush got v=%b addr=%0d want v=0 addr=9", out_valid, inst_addr);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'd9 || out_inst !== 32'h1009) begin
      tests_failed++; $display("FAIL redirect_first got v=%b pc=%0d inst=%h want v=1 pc=9 inst=1009", out_valid, out_pc, out_inst);
    end
  endtask

  task automatic test_halt();
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 18; i++) tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_pc !== 32'd17 || halted !== 1'b0) begin
      tests_failed++; $display("FAIL halt_last got v=%b pc=%0d h=%b want v=1 pc=17 h=0", out_valid, out_pc, halted);
    end
    tick();
    tests_run++;
    if (halted !== 1'b1 || inst_addr !== 32'd18 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL halt_enter got h=%b addr=%0d v=%b want h=1 addr=18 v=0", halted, inst_addr, out_valid);
    end
    tick(); tick(); tick();
    tests_run++;
    if (halted !== 1'b1 || inst_addr !== 32'd18 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL halt_stay got h=%b addr=%0d v=%b want h=1 addr=18 v=0", halted, inst_addr, out_valid);
    end
  endtask

  task automatic test_resume();
    redirect_valid = 1'b1; redirect_addr = 32'd5;
    tick();
    redirect_valid = 1'b0;
    tests_run++;
    if (halted !== 1'b0 || inst_addr !== 32'd5 || out_valid !== 1'b0) begin
      tests_failed++; $display("FAIL resume_redirect got h=%b addr=%0d v=%b want h=0 addr=5 v=0", halted, inst_addr, out_valid);
    end
    for (int k = 5; k <= 7; k++) begin
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_pc !== k) begin
        tests_failed++; $display("FAIL resume_pc%0d got v=%b pc=%0d want v=1 pc=%0d", k, out_valid, out_pc, k);
      end
    end
  endtask

  task automatic test_reset_priority();
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    tests_run++;
    if (out_valid !== 1'b1 || inst_addr !== 32'd4) begin
      tests_failed++; $display("FAIL rstpri_fill got v=%b addr=%0d want v=1 addr=4", out_valid, inst_addr);
    end
    rst = 1'b1; redirect_valid = 1'b1; redirect_addr = 32'd9; out_ready = 1'b1;
    tick();
    rst = 1'b0; redirect_valid = 1'b0;
    tests_run++;
    if (out_valid !== 1'b0 || inst_addr !== 32'd0 || halted !== 1'b0) begin
      tests_failed++; $display("FAIL rstpri got v=%b addr=%0d h=%b want v=0 addr=0 h=0", out_valid, inst_addr, halted);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_resume();
    test_reset_priority();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
